ps2_host_tx: RTL
================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYC, default 10000, SHALL set the clock-inhibit duration in clk cycles (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYC, default 2000000, SHALL set the maximum cycles between successive device clock falling edges (20 ms).
REQ-003 clk  in  1  100 MHz system clock.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 tx_data  in  8  command byte to send to the device (e.g. 8'hF4).
REQ-006 tx_valid  in  1  request; accepted when tx_valid && tx_ready.
REQ-007 tx_ready  out  1  high only in IDLE.
REQ-008 busy  out  1  high in every state except IDLE; the receiver ignores the bus while it is high.
REQ-009 done  out  1  one-cycle pulse at transaction end.
REQ-010 err  out  1  valid with done; 1 means no ACK or timeout.
REQ-011 ps2_clk_i, ps2_data_i  in  1 each  raw PS2Clk/PS2Data pin levels.
REQ-012 ps2_clk_oe, ps2_data_oe  out  1 each  1 drives the line low, 0 releases it (open-collector).

Function
REQ-013 Line inputs SHALL pass a 2-flop synchronizer; a device clock falling edge (fe) is detected on the synchronized clk line.
REQ-014 States: IDLE, INHIBIT, REQ, SHIFT, WAIT_ACK, WAIT_IDLE, FINISH.
REQ-015 IDLE: on accept, latch tx_data, compute parity = ~^tx_data (odd), and go to INHIBIT.
REQ-016 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYC cycles; then assert ps2_data_oe=1 (start bit), release the clock, and go to REQ.
REQ-017 REQ: data held low; the first fe drives bit0 and enters SHIFT.
REQ-018 SHIFT: fe 2..8 drive bits 1..7 LSB-first (oe = ~bit); fe 9 drives parity; fe 10 releases data (stop) and enters WAIT_ACK.
REQ-019 WAIT_ACK: sample the synchronized data at fe 11; 0 means ACK; go to WAIT_IDLE.
REQ-020 WAIT_IDLE: wait until both synchronized lines are high, then go to FINISH.
REQ-021 FINISH: pulse done for one cycle, with err = ~ack; return to IDLE.
REQ-022 Bit changes SHALL occur only on fe; ps2_data_oe is registered.
REQ-023 The timeout counter SHALL clear on entry to REQ and on every fe. If it reaches TIMEOUT_CYC in REQ, SHIFT, WAIT_ACK, or WAIT_IDLE:
- release both lines;
- go to FINISH with err=1.
REQ-024 tx_valid while busy SHALL be ignored; it is not queued.
REQ-025 Back-to-back: a new accept is allowed the cycle after FINISH.
REQ-026 ps2_clk_oe SHALL be 1 only in INHIBIT; no state other than INHIBIT drives clk.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately force:
- state IDLE;
- ps2_clk_oe=0, ps2_data_oe=0;
- done=0, err=0, busy=0;
- counters and the shift register 0.
Reset mid-transaction releases the bus with no done pulse.
REQ-028 After deassertion, tx_ready=1 on the first clock.

Configuration
REQ-029 With PS2_TX_FILTER_EN defined, the synchronized clock line SHALL update only after 8 consecutive identical samples, so glitches shorter than 8 cycles are rejected.
REQ-030 Without PS2_TX_FILTER_EN, the synchronized line is used directly, with 2-cycle latency.

Structure
REQ-031 Package ps2_pkg SHALL hold:
- the state enum;
- constants PS2_CMD_RESET=8'hFF, PS2_CMD_EN_REPORT=8'hF4, PS2_RESP_ACK=8'hFA;
- bit-count constants: 11 device clock falling edges per frame.
REQ-032 Sub-module ps2_line_sync SHALL contain the synchronizer, the optional filter, and falling-edge detection; it is instantiated once per line.

Verification
REQ-033 Send 8'hF4 to a device model clocking at 12.5 kHz -> ps2_clk_oe high for 10000 cycles; data bits 0,0,1,0,1,1,1,1; parity 0; ACK low -> done=1, err=0 for one cycle.
REQ-034 Send 8'hFF with the model not pulling ACK -> parity bit 1, done=1, err=1.
REQ-035 Send 8'h00 with the model never clocking -> err=1 after TIMEOUT_CYC, both oe=0, tx_ready=1.
REQ-036 Assert rst_n low after fe 4 -> both oe=0 in the same cycle; no done; tx_ready=1 after release.
REQ-037 Hold tx_valid high with 8'hF4 then 8'hF3 -> the second byte is accepted only after done, and both frames are correct.
REQ-038 Inject a 3-cycle low glitch on PS2Clk in SHIFT -> with PS2_TX_FILTER_EN no bit advance; without it the bit advances early and the ACK check reports err=1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Honours the PS2_TX_FILTER_EN macro indirectly through ps2_host_tx.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_WAIT_ACK,
        ST_WAIT_IDLE,
        ST_FINISH
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
    localparam logic [7:0] PS2_CMD_EN_REPORT = 8'hF4;
    localparam logic [7:0] PS2_RESP_ACK      = 8'hFA;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_FE   = 11;
    localparam int PS2_FILTER_LEN = 8;

    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer, optional 8-sample glitch filter and falling-edge
// detector for one PS/2 line; FILTER_EN is set from PS2_TX_FILTER_EN by the top.
module ps2_line_sync
    import ps2_pkg::*;
#(
    parameter bit FILTER_EN = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic line_o,
    output logic fe_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic line_s;

    // Idle bus level is high, so reset to 1 to avoid a false edge on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= line_s;
        end
    end

    generate
        if (FILTER_EN) begin : g_filter
            logic [2:0] cnt_q;
            logic [2:0] cnt_d;
            logic       filt_q;
            logic       filt_d;

            always_comb begin
                cnt_d  = '0;
                filt_d = filt_q;
                if (sync_q != filt_q) begin
                    if (cnt_q == 3'(PS2_FILTER_LEN - 1)) begin
                        filt_d = sync_q;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b1;
                end else begin
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end

            assign line_s = filt_q;
        end else begin : g_direct
            assign line_s = sync_q;
        end
    endgenerate

    assign line_o = line_s;
    assign fe_o   = prev_q & ~line_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-collector clk/data drive).
// Define PS2_TX_FILTER_EN to glitch-filter the synchronized device clock.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 10000,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

`ifdef PS2_TX_FILTER_EN
    localparam bit CLK_FILTER = 1'b1;
`else
    localparam bit CLK_FILTER = 1'b0;
`endif

    logic [1:0] line_raw;
    logic [1:0] line_s;
    logic [1:0] line_fe;
    logic       clk_s;
    logic       data_s;
    logic       clk_fe;
    logic       data_fe_unused;

    assign line_raw = {ps2_data_i, ps2_clk_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            ps2_line_sync #(
                .FILTER_EN((gi == 0) ? CLK_FILTER : 1'b0)
            ) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .line_i(line_raw[gi]),
                .line_o(line_s[gi]),
                .fe_o  (line_fe[gi])
            );
        end
    endgenerate

    assign clk_s          = line_s[0];
    assign data_s         = line_s[1];
    assign clk_fe         = line_fe[0];
    assign data_fe_unused = line_fe[1];

    ps2_state_e       state_q, state_d;
    logic [8:0]       shift_q, shift_d;
    logic [3:0]       fe_cnt_q, fe_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             err_q, err_d;
    logic             timed_out;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        fe_cnt_d  = fe_cnt_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        data_oe_d = data_oe_q;
        err_d     = err_q;
        timed_out = 1'b0;

        // Watchdog on the device clock while the device owns the pacing.
        if (state_q inside {ST_REQ, ST_SHIFT, ST_WAIT_ACK, ST_WAIT_IDLE}) begin
            if (clk_fe) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                timed_out = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    shift_d   = {odd_parity(tx_data), tx_data};
                    fe_cnt_d  = '0;
                    inh_cnt_d = '0;
                    err_d     = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt_q == INH_W'(INHIBIT_CYC - 1)) begin
                    data_oe_d = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = ST_REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            ST_REQ, ST_SHIFT: begin
                if (clk_fe) begin
                    fe_cnt_d = fe_cnt_q + 4'd1;
                    // Data bits and parity go out on edges 1..9; edge 10 is the stop bit.
                    if (fe_cnt_q == 4'(PS2_FRAME_FE - 2)) begin
                        data_oe_d = 1'b0;
                        state_d   = ST_WAIT_ACK;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                        state_d   = ST_SHIFT;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (clk_fe) begin
                    err_d   = data_s;
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (timed_out) begin
            data_oe_d = 1'b0;
            err_d     = 1'b1;
            state_d   = ST_FINISH;
        end

        clk_oe_d = (state_d == ST_INHIBIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            fe_cnt_q  <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            fe_cnt_q  <= fe_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            err_q     <= err_d;
        end
    end

    assign tx_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FINISH);
    assign err         = done & err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule
